// File: rtl/fir_coeff_sequencer_if.sv
// fir_coeff_sequencer_if: register-bus write/commit/run controls toward the sequencer and
//   the filter-side controls (coeff bank, ce, rst, valid, status) coming back from it.
// Latency: none here; pure bundle of wires. Backpressure: none, all controls are strobes/levels.
// master = register-bus/filter side, slave = fir_coeff_sequencer. Optional readback ports
// exist only when FIR_SEQ_READBACK_EN is defined.
interface fir_coeff_sequencer_if;
  logic        wr_i;
  logic [2:0]  wr_addr_i;
  logic [17:0] wr_data_i;
  logic        commit_i;
  logic        run_i;
  logic [89:0] coeff_o;
  logic        filt_ce_o;
  logic        filt_rst_o;
  logic        dat_valid_o;
  logic        busy_o;
  logic        commit_done_o;
  logic        bad_addr_o;
`ifdef FIR_SEQ_READBACK_EN
  logic [2:0]  rd_addr_i;
  logic        rd_sel_i;
  logic [17:0] rd_data_o;
`endif

  modport master (
    output wr_i, wr_addr_i, wr_data_i, commit_i, run_i,
`ifdef FIR_SEQ_READBACK_EN
    output rd_addr_i, rd_sel_i,
    input  rd_data_o,
`endif
    input  coeff_o, filt_ce_o, filt_rst_o, dat_valid_o, busy_o, commit_done_o, bad_addr_o
  );

  modport slave (
    input  wr_i, wr_addr_i, wr_data_i, commit_i, run_i,
`ifdef FIR_SEQ_READBACK_EN
    input  rd_addr_i, rd_sel_i,
    output rd_data_o,
`endif
    output coeff_o, filt_ce_o, filt_rst_o, dat_valid_o, busy_o, commit_done_o, bad_addr_o
  );
endinterface

// File: rtl/fir_coeff_sequencer.sv
// fir_coeff_sequencer: shadow/active coefficient banks plus flush/fill sequencing for a 5-tap FIR.
// Latency: commit at edge N -> new coeff_o and filt_rst_o at N+1, valid + commit_done at N+FLUSH+FILL+1.
// Backpressure: none; commits during FLUSH/FILL merge into a one-deep pending flag.
// Ports: clk_i, rst_ni (synchronous, active low), bus (slave modport): wr_i/wr_addr_i/wr_data_i
//   shadow writes, commit_i, run_i, coeff_o (coeff k at [18k +: 18]), filt_ce_o, filt_rst_o,
//   dat_valid_o, busy_o, commit_done_o, bad_addr_o (sticky). All outputs registered.
// Optional: define FIR_SEQ_READBACK_EN for rd_addr_i/rd_sel_i/rd_data_o (1-cycle registered read).
module fir_coeff_sequencer #(
  parameter int FLUSH_CYCLES = 2,
  parameter int FILL_CYCLES  = 9,
  parameter int CNT_BITS     = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  fir_coeff_sequencer_if.slave  bus
);

  localparam int          NUM_TAPS = 5;
  localparam int          CW       = 18;
  localparam logic [2:0]  MAX_ADDR = 3'(NUM_TAPS - 1);
  localparam logic [CNT_BITS-1:0] FLUSH_LD = CNT_BITS'(FLUSH_CYCLES - 1);
  localparam logic [CNT_BITS-1:0] FILL_LD  = CNT_BITS'(FILL_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FLUSH = 2'd1,
    ST_FILL  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                pend_q, pend_d;
  // Set when the current FILL was entered from FLUSH, so reaching RUN confirms a commit.
  logic                flushed_q, flushed_d;
  logic                copy;
  logic                done_d;

  logic [CW-1:0]       shadow_q [NUM_TAPS];
  logic [CW-1:0]       active_q [NUM_TAPS];

  logic                ce_q, frst_q, valid_q, busy_q, done_q, bad_q;
  logic                ce_d, frst_d, valid_d, busy_d;
  logic                wr_ok;

  assign wr_ok = bus.wr_i && (bus.wr_addr_i <= MAX_ADDR);

  // Next-state logic. Outputs are decoded from state_d and registered, so
  // they line up with the state they describe.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    flushed_d = flushed_q;
    copy      = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.commit_i || pend_q) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LD;
          pend_d  = 1'b0;
          copy    = 1'b1;
        end else if (bus.run_i) begin
          state_d   = ST_FILL;
          cnt_d     = FILL_LD;
          flushed_d = 1'b0;
        end
      end

      ST_FLUSH: begin
        if (bus.commit_i) pend_d = 1'b1;
        if (cnt_q == '0) begin
          if (bus.run_i) begin
            state_d   = ST_FILL;
            cnt_d     = FILL_LD;
            flushed_d = 1'b1;
          end else begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      ST_FILL: begin
        if (!bus.run_i) begin
          // Abort without confirmation; any merged commit survives into IDLE.
          state_d = ST_IDLE;
          cnt_d   = '0;
          pend_d  = pend_q | bus.commit_i;
        end else if (cnt_q == '0) begin
          if (pend_q || bus.commit_i) begin
            state_d = ST_FLUSH;
            cnt_d   = FLUSH_LD;
            pend_d  = 1'b0;
            copy    = 1'b1;
          end else begin
            state_d = ST_RUN;
            done_d  = flushed_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
          if (bus.commit_i) pend_d = 1'b1;
        end
      end

      ST_RUN: begin
        if (bus.commit_i) begin
          state_d = ST_FLUSH;
          cnt_d   = FLUSH_LD;
          copy    = 1'b1;
        end else if (!bus.run_i) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    ce_d    = 1'b0;
    frst_d  = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    case (state_d)
      ST_FLUSH: begin ce_d = 1'b1; frst_d = 1'b1; busy_d = 1'b1; end
      ST_FILL:  begin ce_d = 1'b1; busy_d = 1'b1; end
      ST_RUN:   begin ce_d = 1'b1; valid_d = 1'b1; end
      default:  ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pend_q    <= 1'b0;
      flushed_q <= 1'b0;
      ce_q      <= 1'b0;
      frst_q    <= 1'b1;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      bad_q     <= 1'b0;
      for (int k = 0; k < NUM_TAPS; k++) begin
        shadow_q[k] <= '0;
        active_q[k] <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      flushed_q <= flushed_d;
      ce_q      <= ce_d;
      frst_q    <= frst_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      if (bus.wr_i && !wr_ok) bad_q <= 1'b1;
      if (wr_ok) shadow_q[bus.wr_addr_i] <= bus.wr_data_i;
      // Copy reads the pre-edge shadow, so a same-cycle write lands in shadow only.
      if (copy) active_q <= shadow_q;
    end
  end

  logic [NUM_TAPS*CW-1:0] coeff_flat;
  always_comb begin
    coeff_flat = '0;
    for (int k = 0; k < NUM_TAPS; k++) coeff_flat[CW*k +: CW] = active_q[k];
  end

  assign bus.coeff_o       = coeff_flat;
  assign bus.filt_ce_o     = ce_q;
  assign bus.filt_rst_o    = frst_q;
  assign bus.dat_valid_o   = valid_q;
  assign bus.busy_o        = busy_q;
  assign bus.commit_done_o = done_q;
  assign bus.bad_addr_o    = bad_q;

`ifdef FIR_SEQ_READBACK_EN
  logic [CW-1:0] rd_data_q;
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (bus.rd_addr_i <= MAX_ADDR) begin
      rd_data_q <= bus.rd_sel_i ? active_q[bus.rd_addr_i] : shadow_q[bus.rd_addr_i];
    end else begin
      rd_data_q <= '0;
    end
  end
  assign bus.rd_data_o = rd_data_q;
`endif

endmodule
